// File: rtl/bsram_load_ctrl_pkg.sv
// Shared types and constants for the host-driven BSRAM program loader.
// Optional feature macro: LOAD_CHECKSUM_EN (adds a trailing XOR checksum byte).
package bsram_load_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        CHK,
        DONE,
        ERR
    } load_state_t;

    // Byte that starts a load from IDLE or ERR.
    localparam byte DEFAULT_SYNC_BYTE = 8'hA5;

    // States in which the inter-byte watchdog runs.
    function automatic logic is_timed_state(input load_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
               (s == DATA_HI) || (s == CHK);
    endfunction

endpackage

// File: rtl/bsram_load_ctrl_if.sv
// Signal bundle between the loader, the UART receiver, the CPU fetch path and the BSRAM.
// master = the loader itself, slave = everything around it.
interface bsram_load_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_din;
    logic              cpu_hold;
    logic              cpu_restart;
    logic              busy;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  rx_data, rx_valid, cpu_addr,
        output mem_ce, mem_wre, mem_ad, mem_din,
               cpu_hold, cpu_restart, busy, load_err, words_loaded
    );

    modport slave (
        output rx_data, rx_valid, cpu_addr,
        input  mem_ce, mem_wre, mem_ad, mem_din,
               cpu_hold, cpu_restart, busy, load_err, words_loaded
    );
endinterface

// File: rtl/bsram_load_ctrl_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYCLES-1.
module load_timeout #(
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count while enabled, saturating at the terminal value; clear wins.
    // NOTE: clocked state uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/bsram_load_ctrl.sv
// Owner of the single-port program BSRAM. Passes CPU fetch addresses through
// until a sync byte arrives, then holds the CPU, writes a length-prefixed
// program of 16-bit words, pulses cpu_restart and hands the port back.
// Optional feature macro: LOAD_CHECKSUM_EN (CHK state, XOR of all data bytes).
module bsram_load_ctrl
    import bsram_load_pkg::*;
#(
    parameter int         ADDR_W         = 11,
    parameter int         DATA_W         = 16,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 27000000
) (
    input logic               clk,
    input logic               rst_n,
    bsram_load_ctrl_if.master bus
);
    // Largest accepted length: one full memory image.
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

`ifdef LOAD_CHECKSUM_EN
    localparam load_state_t END_STATE = CHK;
`else
    localparam load_state_t END_STATE = DONE;
`endif

    load_state_t       state_q, state_d;
    logic [15:0]       len_q;
    logic [7:0]        lo_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W-1:0] load_addr_q;
    logic [ADDR_W:0]   words_q;
    logic              ce_q, wre_q, hold_q, restart_q, busy_q, err_q;
    logic              tmo_expired;
    logic              sync_seen;
    logic              last_word;
    logic [15:0]       len_rx;
`ifdef LOAD_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign sync_seen = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign len_rx    = {bus.rx_data, len_q[7:0]};
    assign last_word = (17'(words_q) + 17'd1) == {1'b0, len_q};

    load_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.rx_valid || !is_timed_state(state_q)),
        .en      (is_timed_state(state_q)),
        .expired (tmo_expired)
    );

    // Next-state logic; an accepted byte takes priority over a same-cycle timeout.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE, ERR: if (sync_seen) state_d = LEN_LO;
            LEN_LO: begin
                if (bus.rx_valid)     state_d = LEN_HI;
                else if (tmo_expired) state_d = ERR;
            end
            LEN_HI: begin
                if (bus.rx_valid) begin
                    if (len_rx == 16'd0)                state_d = END_STATE;
                    else if ({1'b0, len_rx} > MAX_LEN) state_d = ERR;
                    else                                state_d = DATA_LO;
                end else if (tmo_expired) begin
                    state_d = ERR;
                end
            end
            DATA_LO: begin
                if (bus.rx_valid)     state_d = DATA_HI;
                else if (tmo_expired) state_d = ERR;
            end
            DATA_HI: begin
                if (bus.rx_valid)     state_d = WRITE;
                else if (tmo_expired) state_d = ERR;
            end
            WRITE: state_d = last_word ? END_STATE : DATA_LO;
`ifdef LOAD_CHECKSUM_EN
            CHK: begin
                if (bus.rx_valid)     state_d = (bus.rx_data == csum_q) ? DONE : ERR;
                else if (tmo_expired) state_d = ERR;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered control outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ce_q      <= 1'b0;
            wre_q     <= 1'b0;
            hold_q    <= 1'b0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ce_q      <= 1'b1;
            wre_q     <= (state_d == WRITE);
            hold_q    <= (state_d != IDLE);
            restart_q <= (state_d == DONE);
            busy_q    <= (state_d != IDLE) && (state_d != ERR);
            err_q     <= (state_d == ERR);
        end
    end

    // Length, data word assembly, write address and word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            lo_q        <= '0;
            din_q       <= '0;
            load_addr_q <= '0;
            words_q     <= '0;
        end else begin
            case (state_q)
                IDLE, ERR: begin
                    if (sync_seen) begin
                        words_q     <= '0;
                        load_addr_q <= '0;
                    end
                end
                LEN_LO:  if (bus.rx_valid) len_q[7:0]  <= bus.rx_data;
                LEN_HI:  if (bus.rx_valid) len_q[15:8] <= bus.rx_data;
                DATA_LO: if (bus.rx_valid) lo_q        <= bus.rx_data;
                DATA_HI: if (bus.rx_valid) din_q       <= DATA_W'({bus.rx_data, lo_q});
                WRITE: begin
                    words_q <= words_q + 1'b1;
                    // The final word leaves the address in range; it is never reused.
                    if (!last_word) load_addr_q <= load_addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    // Running XOR of every data byte of the current load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (((state_q == IDLE) || (state_q == ERR)) && sync_seen) begin
            csum_q <= '0;
        end else if (((state_q == DATA_LO) || (state_q == DATA_HI)) && bus.rx_valid) begin
            csum_q <= csum_q ^ bus.rx_data;
        end
    end
`endif

    assign bus.mem_ce       = ce_q;
    assign bus.mem_wre      = wre_q;
    assign bus.mem_ad       = hold_q ? load_addr_q : bus.cpu_addr;
    assign bus.mem_din      = din_q;
    assign bus.cpu_hold     = hold_q;
    assign bus.cpu_restart  = restart_q;
    assign bus.busy         = busy_q;
    assign bus.load_err     = err_q;
    assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_bsram_load_ctrl.sv
// Bench for bsram_load_ctrl: byte-level UART stimulus, a write scoreboard
// checked on the falling edge, and scenario tasks run in sequence.
module tb_bsram_load_ctrl;
    import bsram_load_pkg::*;

    localparam int         ADDR_W = 11;
    localparam int         DATA_W = 16;
    localparam int         TMO    = 100;
    localparam int         GAP    = 2;
    localparam logic [7:0] SYNC   = DEFAULT_SYNC_BYTE;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bsram_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    bsram_load_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total        = 0;
    int          bad          = 0;
    int          restart_cnt  = 0;
    int          exp_restarts = 0;
    logic        restart_prev = 1'b0;
    wr_t         exp_q[$];
    logic [15:0] data_q[$];
    wr_t         mon_e;

    // Write scoreboard and restart-pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_wre === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got ad=%h din=%h, expected no write", bus.mem_ad, bus.mem_din);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.mem_ad !== mon_e.addr || bus.mem_din !== mon_e.data || bus.cpu_hold !== 1'b1) begin
                    bad++;
                    $display("FAIL write_check: got ad=%h din=%h hold=%b, expected ad=%h din=%h hold=1",
                             bus.mem_ad, bus.mem_din, bus.cpu_hold, mon_e.addr, mon_e.data);
                end
            end
        end
        if (bus.cpu_restart === 1'b1) begin
            restart_cnt++;
            total++;
            if (restart_prev === 1'b1) begin
                bad++;
                $display("FAIL restart_width: cpu_restart high for 2+ cycles, expected 1-cycle pulse");
            end
        end
        restart_prev = bus.cpu_restart;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int done_delay(input int words);
`ifdef LOAD_CHECKSUM_EN
        return 0;
`else
        return (words == 0) ? 0 : 1;
`endif
    endfunction

    // Drive one byte after GAP idle cycles; returns 1 unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        repeat (GAP) @(posedge clk);
        #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    // Full load of data_q with the given length field; expected writes are queued as bytes go out.
    task automatic send_load(input logic [15:0] len, input bit bad_cs);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(SYNC);
        total++;
        if (bus.cpu_hold !== 1'b1 || bus.busy !== 1'b1 || bus.load_err !== 1'b0 || bus.words_loaded !== '0) begin
            bad++;
            $display("FAIL after_sync: got hold=%b busy=%b err=%b words=%0d, expected 1 1 0 0",
                     bus.cpu_hold, bus.busy, bus.load_err, bus.words_loaded);
        end
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < data_q.size(); i++) begin
            wr_t e;
            e.addr = ADDR_W'(i);
            e.data = data_q[i];
            exp_q.push_back(e);
            send_byte(data_q[i][7:0]);
            send_byte(data_q[i][15:8]);
            cs = cs ^ data_q[i][7:0] ^ data_q[i][15:8];
        end
`ifdef LOAD_CHECKSUM_EN
        send_byte(bad_cs ? (cs ^ 8'h01) : cs);
`else
        if (bad_cs) cs = ~cs;
`endif
    endtask

    // Expect the restart pulse exp_delay cycles after the last byte, then release.
    task automatic wait_restart(input string name, input int exp_delay, input logic [ADDR_W:0] exp_words);
        int n;
        n = -1;
        for (int i = 0; i <= 10; i++) begin
            if (bus.cpu_restart === 1'b1) begin
                n = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        exp_restarts++;
        total++;
        if (n != exp_delay) begin
            bad++;
            $display("FAIL %s_restart_latency: got %0d cycles, expected %0d", name, n, exp_delay);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.cpu_hold !== 1'b0 || bus.busy !== 1'b0 || bus.load_err !== 1'b0 || bus.words_loaded !== exp_words) begin
            bad++;
            $display("FAIL %s_release: got hold=%b busy=%b err=%b words=%0d, expected 0 0 0 %0d",
                     name, bus.cpu_hold, bus.busy, bus.load_err, bus.words_loaded, exp_words);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending_writes: got %0d missing writes, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cpu_addr = 11'h123;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.mem_ce !== 1'b0 || bus.mem_wre !== 1'b0 || bus.mem_din !== '0 || bus.cpu_hold !== 1'b0 ||
            bus.cpu_restart !== 1'b0 || bus.busy !== 1'b0 || bus.load_err !== 1'b0 || bus.words_loaded !== '0) begin
            bad++;
            $display("FAIL reset_values: got ce=%b wre=%b din=%h hold=%b rst=%b busy=%b err=%b words=%0d, expected all 0",
                     bus.mem_ce, bus.mem_wre, bus.mem_din, bus.cpu_hold, bus.cpu_restart, bus.busy, bus.load_err, bus.words_loaded);
        end
        total++;
        if (bus.mem_ad !== 11'h123) begin
            bad++;
            $display("FAIL reset_addr_mux: got mem_ad=%h, expected 123", bus.mem_ad);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.mem_ce !== 1'b1) begin
            bad++;
            $display("FAIL ce_after_release: got mem_ce=%b, expected 1", bus.mem_ce);
        end
        send_byte(8'h5A);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.mem_ce !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.busy !== 1'b0 || bus.mem_ad !== 11'h123) begin
            bad++;
            $display("FAIL idle_ignore: got ce=%b hold=%b busy=%b ad=%h, expected 1 0 0 123",
                     bus.mem_ce, bus.cpu_hold, bus.busy, bus.mem_ad);
        end
    endtask

    task automatic test_basic_load();
        bus.cpu_addr = 11'h7FF;
        data_q = '{16'hA001, 16'h0078, 16'h0092};
        send_load(16'd3, 1'b0);
        wait_restart("basic", done_delay(3), 12'd3);
        total++;
        if (bus.mem_ad !== 11'h7FF) begin
            bad++;
            $display("FAIL basic_addr_back: got mem_ad=%h, expected 7ff", bus.mem_ad);
        end
    endtask

    task automatic test_zero_len();
        data_q = {};
        send_load(16'd0, 1'b0);
        wait_restart("zero_len", 0, 12'd0);
    endtask

    task automatic test_len_error();
        data_q = {};
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h08);
        total++;
        if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL len_0801: got err=%b hold=%b busy=%b, expected 1 1 0", bus.load_err, bus.cpu_hold, bus.busy);
        end
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h09);
        total++;
        if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0 || bus.words_loaded !== '0) begin
            bad++;
            $display("FAIL len_0901: got err=%b hold=%b busy=%b words=%0d, expected 1 1 0 0",
                     bus.load_err, bus.cpu_hold, bus.busy, bus.words_loaded);
        end
        send_byte(8'h11);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.load_err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL err_ignore: got err=%b busy=%b, expected 1 0", bus.load_err, bus.busy);
        end
        data_q = '{16'h1234};
        send_load(16'd1, 1'b0);
        wait_restart("err_recover", done_delay(1), 12'd1);
    endtask

    task automatic test_sync_as_data();
        data_q = '{16'hA5A5, 16'h00A5};
        send_load(16'd2, 1'b0);
        wait_restart("sync_data", done_delay(2), 12'd2);
    endtask

    task automatic test_timeout();
        int n;
        data_q = {};
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.load_err === 1'b1) begin
                n = i;
                break;
            end
        end
        total++;
        if (n != TMO) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", n, TMO);
        end
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_state: got err=%b hold=%b busy=%b, expected 1 1 0", bus.load_err, bus.cpu_hold, bus.busy);
        end
        send_load(16'd0, 1'b0);
        wait_restart("tmo_recover", 0, 12'd0);
    endtask

    task automatic test_full_len();
        data_q = {};
        for (int i = 0; i < 2 ** ADDR_W; i++) begin
            data_q.push_back(16'(i * 40503) ^ 16'h3C5A);
        end
        send_load(16'(2 ** ADDR_W), 1'b0);
        wait_restart("full_len", done_delay(2 ** ADDR_W), 12'h800);
    endtask

    task automatic test_reset_mid_load();
        wr_t e;
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h00);
        e.addr = '0;
        e.data = 16'hBEEF;
        exp_q.push_back(e);
        send_byte(8'hEF);
        send_byte(8'hBE);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.cpu_hold !== 1'b0 || bus.busy !== 1'b0 || bus.mem_wre !== 1'b0 || bus.words_loaded !== '0) begin
            bad++;
            $display("FAIL mid_reset: got hold=%b busy=%b wre=%b words=%0d, expected 0 0 0 0",
                     bus.cpu_hold, bus.busy, bus.mem_wre, bus.words_loaded);
        end
        @(negedge clk) rst_n = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL mid_reset_write: got %0d missing writes, expected 0", exp_q.size());
        end
        data_q = {};
        send_load(16'd0, 1'b0);
        wait_restart("post_reset", 0, 12'd0);
    endtask

`ifdef LOAD_CHECKSUM_EN
    task automatic test_checksum();
        data_q = '{16'h1234};
        send_load(16'd1, 1'b0);
        wait_restart("csum_good", 0, 12'd1);
        send_load(16'd1, 1'b1);
        total++;
        if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL csum_bad: got err=%b hold=%b busy=%b, expected 1 1 0", bus.load_err, bus.cpu_hold, bus.busy);
        end
        repeat (5) @(posedge clk);
        data_q = {};
        send_load(16'd0, 1'b0);
        wait_restart("csum_recover", 0, 12'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_zero_len();
        test_len_error();
        test_sync_as_data();
        test_timeout();
        test_reset_mid_load();
`ifdef LOAD_CHECKSUM_EN
        test_checksum();
`endif
        test_full_len();
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (restart_cnt != exp_restarts) begin
            bad++;
            $display("FAIL restart_count: got %0d pulses, expected %0d", restart_cnt, exp_restarts);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsram_load_ctrl.md
Name: bsram_load_ctrl

Overview:
Sequencer and owner of the single-port program BSRAM.
- Normally passes CPU fetch addresses straight to the BSRAM.
- On a sync byte from the UART receiver, it holds the CPU, takes over the BSRAM port and writes a length-prefixed program of 16-bit words.
- Afterwards it pulses a CPU restart and hands the port back.
- Sits between the UART byte receiver, the CPU fetch path and the Gowin_SP instance. It replaces the fixed boot-ROM loader with a host-driven one.

Parameters:
ADDR_W, 11, BSRAM word-address width; depth = 2**ADDR_W words
DATA_W, 16, BSRAM word width (fixed 16; two bytes per word)
SYNC_BYTE, 8'hA5, byte that starts a load when in IDLE or ERR
TIMEOUT_CYCLES, 27000000, max clk cycles between bytes inside a load before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
cpu_addr  in  ADDR_W  CPU fetch word address (already pc/2)
mem_ce  out  1  BSRAM chip enable
mem_wre  out  1  BSRAM write enable
mem_ad  out  ADDR_W  BSRAM address
mem_din  out  DATA_W  BSRAM write data
cpu_hold  out  1  1 = CPU must stall
cpu_restart  out  1  one-cycle pulse: CPU resets its PC to 0
busy  out  1  1 while in any state other than IDLE/ERR
load_err  out  1  sticky error, cleared by next SYNC_BYTE
words_loaded  out  ADDR_W+1  words written by the last/current load

Behaviour:
Reset values:
- mem_ce=0, mem_wre=0, mem_din=0, cpu_hold=0, cpu_restart=0, busy=0, load_err=0, words_loaded=0
- State IDLE, internal load_addr=0, len=0, timer=0
- mem_ce goes 1 on the first clk after reset release and stays 1.

Address mux:
- mem_ad = cpu_addr (combinational) when cpu_hold=0; otherwise mem_ad = load_addr.

States (all outputs except mem_ad are registered):
- IDLE: rx_valid with SYNC_BYTE -> LEN_LO, cpu_hold<=1, load_err<=0, words_loaded<=0. Other bytes are ignored.
- LEN_LO: on byte -> len[7:0], then LEN_HI.
- LEN_HI: on byte -> len[15:8].
  - len==0 -> DONE.
  - len > 2**ADDR_W -> ERR.
  - otherwise -> DATA_LO with load_addr=0.
- DATA_LO: on byte -> lo reg, then DATA_HI.
- DATA_HI: on byte -> mem_din<={byte,lo}, then WRITE.
- WRITE (1 cycle):
  - mem_wre=1 for exactly this cycle at load_addr; words_loaded+1; load_addr+1.
  - If words_loaded+1==len -> DONE (or CHK if the optional feature is enabled), else DATA_LO.
  - rx_valid in this cycle is ignored; UART byte spacing makes this unreachable.
- DONE (1 cycle): cpu_restart=1. Next cycle cpu_hold=0 and state IDLE.
- ERR: cpu_hold stays 1, load_err=1. SYNC_BYTE -> LEN_LO as from IDLE; other bytes are ignored.

Timeout and limits:
- Timer resets on every accepted byte and counts in LEN_LO/LEN_HI/DATA_LO/DATA_HI. Reaching TIMEOUT_CYCLES-1 -> ERR.
- load_addr never wraps; the len limit guarantees this. len==2**ADDR_W writes every word.
- SYNC_BYTE received mid-load is treated as data, not as a restart.
- Asynchronous reset mid-load: returns to IDLE with cpu_hold=0. Memory contents are undefined and not the block's concern.

Optional Feature:
Macro LOAD_CHECKSUM_EN.
- Defined: after the last WRITE, state CHK expects one byte equal to the XOR of all data bytes (lo and hi, in order).
  - Match -> DONE.
  - Mismatch -> ERR.
  - The timeout applies in CHK.
  - With len==0 the expected checksum is 8'h00.
- Undefined: no CHK state; the last WRITE goes directly to DONE.

Decomposition:
- Package bsram_load_pkg holds:
  - typedef enum logic [3:0] load_state_t (IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHK, DONE, ERR)
  - localparam byte default SYNC_BYTE
- One sub-module, load_timeout: counter with clear, enable and expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset, no rx: cpu_addr=0x123 -> mem_ad=0x123, cpu_hold=0, mem_wre never 1, mem_ce=1 after release.
2. Bytes A5 03 00 01 A0 78 00 92 00 -> writes [0]=A001, [1]=0078, [2]=0092, each mem_wre exactly 1 cycle; then one cpu_restart pulse, cpu_hold falls, words_loaded=3.
3. A5 00 00 -> no write; DONE/cpu_restart immediately after the length; load_err=0.
4. A5 01 09 (len 0x0901 > 2048) -> ERR, load_err=1, cpu_hold=1. Then A5 01 00 34 12 -> [0]=1234, load_err=0, hold released.
5. A5 02 00 11, then silence with TIMEOUT_CYCLES=100 -> ERR exactly 100 cycles after the last byte; no further writes.
6. With LOAD_CHECKSUM_EN: A5 01 00 34 12 26 -> DONE; checksum 27 instead -> ERR, load_err=1, cpu_restart never pulses.
